// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: in-order expected/actual FPU result checker with counters and first-fail capture.
// Optional define FPU_SB_NAN_CANON_EN: any NaN matches any NaN in the data compare.
`default_nettype none

module fpu_scoreboard #(
  parameter int WIDTH        = 32,
  parameter int EXP_W        = 8,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_exp_valid,
  output logic             o_exp_ready,
  input  logic [WIDTH-1:0] i_exp_data,
  input  logic [4:0]       i_exp_flags,
  input  logic             i_dut_valid,
  input  logic [WIDTH-1:0] i_dut_data,
  input  logic [4:0]       i_dut_flags,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic [CNT_W-1:0] o_flag_fail_cnt,
  output logic [CNT_W-1:0] o_case_idx,
  output logic             o_underrun_err,
  output logic             o_first_fail_vld,
  output logic [CNT_W-1:0] o_first_fail_idx,
  output logic [WIDTH-1:0] o_first_fail_got,
  output logic [WIDTH-1:0] o_first_fail_exp,
  output logic             o_halted,
  output logic             o_fifo_empty,
  output logic             o_fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 5;
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_flag_fail_cnt;
  logic [CNT_W-1:0] r_case_idx;
  logic             r_underrun_err;
  logic             r_ff_vld;
  logic [CNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0] r_ff_got;
  logic [WIDTH-1:0] r_ff_exp;

  logic             w_empty;
  logic             w_full;
  logic             w_active;
  logic             w_push;
  logic             w_pop;
  logic             w_underrun;
  logic [EW-1:0]    w_head;
  logic [WIDTH-1:0] w_head_data;
  logic [4:0]       w_head_flags;
  logic             w_data_match;
  logic             w_flag_match;
  logic             w_stop;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_data  = w_head[EW-1:5];
  assign w_head_flags = w_head[4:0];
  assign w_active     = (r_state != S_HALT);
  assign w_push       = i_exp_valid && o_exp_ready;
  assign w_pop        = i_dut_valid && !w_empty && w_active;
  assign w_underrun   = i_dut_valid && w_empty && w_active;
  assign w_flag_match = (w_head_flags == i_dut_flags);
  assign w_stop       = (STOP_ON_FAIL != 0) && w_pop && !w_data_match;

`ifdef FPU_SB_NAN_CANON_EN
  localparam int MAN_W = WIDTH - 1 - EXP_W;

  function automatic logic f_is_nan(input logic [WIDTH-1:0] x);
    return (&x[WIDTH-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  assign w_data_match = (w_head_data == i_dut_data) ||
                        (f_is_nan(w_head_data) && f_is_nan(i_dut_data));
`else
  assign w_data_match = (w_head_data == i_dut_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_stop) w_state_nxt = S_HALT;
        else if (w_push) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_stop) w_state_nxt = S_HALT;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  always_comb begin
    o_exp_ready = 1'b0;
    o_halted    = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: o_exp_ready = !w_full;
      S_HALT:        o_halted    = 1'b1;
      default:       o_exp_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_exp_data, i_exp_flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_flag_fail_cnt <= '0;
      r_case_idx      <= '0;
      r_underrun_err  <= 1'b0;
      r_ff_vld        <= 1'b0;
      r_ff_idx        <= '0;
      r_ff_got        <= '0;
      r_ff_exp        <= '0;
    end else if (i_clear) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_flag_fail_cnt <= '0;
      r_case_idx      <= '0;
      r_underrun_err  <= 1'b0;
      r_ff_vld        <= 1'b0;
      r_ff_idx        <= '0;
      r_ff_got        <= '0;
      r_ff_exp        <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_underrun) r_underrun_err <= 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_case_idx <= f_sat_inc(r_case_idx);
        if (w_data_match) begin
          r_pass_cnt <= f_sat_inc(r_pass_cnt);
        end else begin
          r_fail_cnt <= f_sat_inc(r_fail_cnt);
          if (!r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_idx <= r_case_idx;
            r_ff_got <= i_dut_data;
            r_ff_exp <= w_head_data;
          end
        end
        if (!w_flag_match) r_flag_fail_cnt <= f_sat_inc(r_flag_fail_cnt);
      end
    end
  end

  assign o_pass_cnt       = r_pass_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_flag_fail_cnt  = r_flag_fail_cnt;
  assign o_case_idx       = r_case_idx;
  assign o_underrun_err   = r_underrun_err;
  assign o_first_fail_vld = r_ff_vld;
  assign o_first_fail_idx = r_ff_idx;
  assign o_first_fail_got = r_ff_got;
  assign o_first_fail_exp = r_ff_exp;
  assign o_fifo_empty     = w_empty;
  assign o_fifo_full      = w_full;

endmodule

`default_nettype wire

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard: directed table, hand sequences and randomized traffic against a queue model.
`default_nettype none

module tb_fpu_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        clear, ev, dv, ready, under, ffv, halted, empty, full;
  logic [31:0] ed, dd, ffgot, ffexp;
  logic [4:0]  ef, df;
  logic [15:0] pass_c, fail_c, ffail_c, idx, ffidx;

  logic        h_clear, h_ev, h_dv, h_ready, h_under, h_ffv, h_halted, h_empty, h_full;
  logic [31:0] h_ed, h_dd, h_ffgot, h_ffexp;
  logic [4:0]  h_ef, h_df;
  logic [2:0]  h_pass, h_fail, h_ffail, h_idx, h_ffidx;

  fpu_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_exp_valid(ev), .o_exp_ready(ready),
    .i_exp_data(ed), .i_exp_flags(ef), .i_dut_valid(dv), .i_dut_data(dd), .i_dut_flags(df),
    .o_pass_cnt(pass_c), .o_fail_cnt(fail_c), .o_flag_fail_cnt(ffail_c), .o_case_idx(idx),
    .o_underrun_err(under), .o_first_fail_vld(ffv), .o_first_fail_idx(ffidx),
    .o_first_fail_got(ffgot), .o_first_fail_exp(ffexp), .o_halted(halted),
    .o_fifo_empty(empty), .o_fifo_full(full)
  );

  fpu_scoreboard #(.DEPTH(4), .CNT_W(3), .STOP_ON_FAIL(1)) hdut (
    .clk(clk), .rst_n(rst_n), .i_clear(h_clear), .i_exp_valid(h_ev), .o_exp_ready(h_ready),
    .i_exp_data(h_ed), .i_exp_flags(h_ef), .i_dut_valid(h_dv), .i_dut_data(h_dd),
    .i_dut_flags(h_df), .o_pass_cnt(h_pass), .o_fail_cnt(h_fail), .o_flag_fail_cnt(h_ffail),
    .o_case_idx(h_idx), .o_underrun_err(h_under), .o_first_fail_vld(h_ffv),
    .o_first_fail_idx(h_ffidx), .o_first_fail_got(h_ffgot), .o_first_fail_exp(h_ffexp),
    .o_halted(h_halted), .o_fifo_empty(h_empty), .o_fifo_full(h_full)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
    end
  endtask

`ifdef FPU_SB_NAN_CANON_EN
  localparam int NP = 1;
`else
  localparam int NP = 0;
`endif

  // Reference model: a queue of expected entries plus plain integer counters.
  typedef struct packed { logic [31:0] d; logic [4:0] f; } ent_t;
  ent_t        q[$];
  int          m_pass, m_fail, m_ff, m_idx, m_ffidx;
  bit          m_under, m_ffv;
  logic [31:0] m_ffgot, m_ffexp;

  function automatic void m_reset();
    q.delete();
    m_pass = 0; m_fail = 0; m_ff = 0; m_idx = 0; m_ffidx = 0;
    m_under = 0; m_ffv = 0; m_ffgot = 0; m_ffexp = 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit data_ok(input logic [31:0] e, input logic [31:0] g);
    if (e == g) return 1'b1;
    if (NP == 1 && is_nan(e) && is_nan(g)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("pass_cnt", pass_c, m_pass);
    chk("fail_cnt", fail_c, m_fail);
    chk("flag_fail_cnt", ffail_c, m_ff);
    chk("case_idx", idx, m_idx);
    chk("underrun_err", under, m_under);
    chk("first_fail_vld", ffv, m_ffv);
    chk("first_fail_idx", ffidx, m_ffidx);
    chk("first_fail_got", ffgot, m_ffgot);
    chk("first_fail_exp", ffexp, m_ffexp);
    chk("fifo_empty", empty, q.size() == 0);
    chk("fifo_full", full, q.size() == 16);
    chk("halted", halted, 0);
  endtask

  task automatic cyc(input bit clr, input bit ev_i, input logic [31:0] ed_i,
                     input logic [4:0] ef_i, input bit dv_i, input logic [31:0] dd_i,
                     input logic [4:0] df_i);
    int   sz;
    ent_t h;
    clear = clr; ev = ev_i; ed = ed_i; ef = ef_i; dv = dv_i; dd = dd_i; df = df_i;
    #1;
    chk("exp_ready", ready, q.size() < 16);
    if (clr) begin
      m_reset();
    end else begin
      sz = q.size();
      if (dv_i) begin
        if (sz == 0) begin
          m_under = 1;
        end else begin
          h = q.pop_front();
          if (data_ok(h.d, dd_i)) begin
            m_pass = sat(m_pass);
          end else begin
            if (!m_ffv) begin
              m_ffv = 1; m_ffidx = m_idx; m_ffgot = dd_i; m_ffexp = h.d;
            end
            m_fail = sat(m_fail);
          end
          if (h.f != df_i) m_ff = sat(m_ff);
          m_idx = sat(m_idx);
        end
      end
      if (ev_i && sz < 16) q.push_back('{d: ed_i, f: ef_i});
    end
    @(posedge clk); #1;
    clear = 0; ev = 0; dv = 0;
    check_all();
  endtask

  task automatic hcyc(input bit clr, input bit ev_i, input logic [31:0] ed_i,
                      input bit dv_i, input logic [31:0] dd_i);
    h_clear = clr; h_ev = ev_i; h_ed = ed_i; h_ef = 5'b0;
    h_dv = dv_i; h_dd = dd_i; h_df = 5'b0;
    @(posedge clk); #1;
    h_clear = 0; h_ev = 0; h_dv = 0;
  endtask

  typedef struct {
    bit ev; logic [31:0] ed; logic [4:0] ef;
    bit dv; logic [31:0] dd; logic [4:0] df;
    int p; int f; int ff; int ix;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 0; ev = 0; dv = 0; ed = 0; ef = 0; dd = 0; df = 0;
    h_clear = 0; h_ev = 0; h_dv = 0; h_ed = 0; h_ef = 0; h_dd = 0; h_df = 0;
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_all();
    chk("h_reset_empty", h_empty, 1);
    chk("h_reset_halted", h_halted, 0);

    // Single push, result three cycles later; counters update one cycle after dut_valid.
    cyc(0, 1, 32'h40400000, 5'b0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pre_pop_pass", pass_c, 0);
    cyc(0, 0, 0, 0, 1, 32'h40400000, 5'b0);
    chk("first_pass", pass_c, 1);
    chk("first_idx", idx, 1);

    // Fill to 16, reject the 17th, then drain with matching results.
    for (int i = 0; i < 17; i++) cyc(0, 1, 32'h3F000000 + i, i[4:0], 0, 0, 0);
    chk("full_flag", full, 1);
    chk("full_ready", ready, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 32'h3F000000 + i, i[4:0]);
    chk("drain_pass", pass_c, 17);
    chk("drain_empty", empty, 1);

    // Clear beats a simultaneous push and pop.
    cyc(0, 1, 32'h11111111, 5'b0, 0, 0, 0);
    cyc(0, 1, 32'h22222222, 5'b0, 0, 0, 0);
    cyc(1, 1, 32'h33333333, 5'b0, 1, 32'h11111111, 5'b0);
    chk("clear_empty", empty, 1);
    chk("clear_pass", pass_c, 0);

    tbl[0]  = '{1, 32'h3F800000, 5'b00000, 0, 0, 0,                          0, 0, 0, 0};
    tbl[1]  = '{1, 32'h40000000, 5'b00000, 0, 0, 0,                          0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,                   0, 0, 0,                          0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,                   1, 32'h3F800000, 5'b00000,        1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0,                   1, 32'h40000001, 5'b00000,        1, 1, 0, 2};
    tbl[5]  = '{0, 0, 0,                   1, 32'h12345678, 5'b00000,        1, 1, 0, 2};
    tbl[6]  = '{1, 32'h7F800000, 5'b01001, 1, 32'h7F800000, 5'b01001,        1, 1, 0, 2};
    tbl[7]  = '{0, 0, 0,                   1, 32'h7F800000, 5'b01000,        2, 1, 1, 3};
    tbl[8]  = '{1, 32'h7FC00000, 5'b00001, 0, 0, 0,                          2, 1, 1, 3};
    tbl[9]  = '{0, 0, 0,                   1, 32'hFFFFFFFF, 5'b00001, 2+NP, 2-NP, 1, 4};
    tbl[10] = '{1, 32'h40400000, 5'b00000, 0, 0, 0,                   2+NP, 2-NP, 1, 4};
    tbl[11] = '{1, 32'h40800000, 5'b00000, 1, 32'h40400000, 5'b00000, 3+NP, 2-NP, 1, 5};
    tbl[12] = '{0, 0, 0,                   1, 32'h40800000, 5'b00010, 4+NP, 2-NP, 2, 6};
    for (int i = 0; i < 13; i++) begin
      cyc(0, tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].dv, tbl[i].dd, tbl[i].df);
      chk($sformatf("tbl%0d_pass", i), pass_c, tbl[i].p);
      chk($sformatf("tbl%0d_fail", i), fail_c, tbl[i].f);
      chk($sformatf("tbl%0d_flagfail", i), ffail_c, tbl[i].ff);
      chk($sformatf("tbl%0d_idx", i), idx, tbl[i].ix);
    end
    chk("tbl_underrun", under, 1);
    chk("tbl_ff_idx", ffidx, 1);
    chk("tbl_ff_got", ffgot, 32'h40000001);
    chk("tbl_ff_exp", ffexp, 32'h40000000);

    // Reset mid-stream discards queued entries.
    cyc(0, 1, 32'hAAAA0000, 5'b0, 0, 0, 0);
    cyc(0, 1, 32'hBBBB0000, 5'b0, 0, 0, 0);
    rst_n = 0;
    #2 rst_n = 1;
    m_reset();
    #1 check_all();
    cyc(0, 0, 0, 0, 1, 32'hAAAA0000, 5'b0);
    chk("post_reset_underrun", under, 1);
    chk("post_reset_idx", idx, 0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] r_ed, r_dd;
      logic [4:0]  r_ef, r_df;
      int          pick;
      r_ed = $urandom;
      if ($urandom_range(0, 7) == 0) r_ed[30:23] = 8'hFF;
      r_ef = 5'($urandom_range(0, 31));
      r_dd = $urandom;
      r_df = 5'($urandom_range(0, 31));
      if (q.size() > 0) begin
        pick = $urandom_range(0, 9);
        if (pick < 6) begin
          r_dd = q[0].d; r_df = q[0].f;
        end else if (pick < 8) begin
          r_dd = q[0].d ^ (32'h1 << $urandom_range(0, 31));
          r_df = q[0].f;
        end
        if ($urandom_range(0, 4) == 0) r_df = ~q[0].f;
      end
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, r_ed, r_ef,
          $urandom_range(0, 9) < 4, r_dd, r_df);
    end

    // Halt behaviour, fill limit and saturation on the small STOP_ON_FAIL instance.
    hcyc(0, 1, 32'h3F800000, 0, 0);
    hcyc(0, 1, 32'h40000000, 0, 0);
    hcyc(0, 1, 32'h40400000, 0, 0);
    hcyc(0, 0, 0, 1, 32'h3F800000);
    chk("h_pass1", h_pass, 1);
    chk("h_halted_before", h_halted, 0);
    hcyc(0, 0, 0, 1, 32'h40000001);
    chk("h_halted", h_halted, 1);
    chk("h_fail1", h_fail, 1);
    chk("h_ready_halt", h_ready, 0);
    chk("h_ff_idx", h_ffidx, 1);
    hcyc(0, 0, 0, 1, 32'h40400000);
    chk("h_idx_frozen", h_idx, 2);
    chk("h_pass_frozen", h_pass, 1);
    chk("h_not_empty", h_empty, 0);
    chk("h_no_underrun", h_under, 0);
    hcyc(1, 0, 0, 0, 0);
    chk("h_clear_halted", h_halted, 0);
    chk("h_clear_cnt", {h_pass, h_fail, h_ffail, h_idx}, 0);
    chk("h_clear_ffv", h_ffv, 0);
    chk("h_clear_ready", h_ready, 1);
    chk("h_clear_empty", h_empty, 1);
    for (int i = 0; i < 5; i++) hcyc(0, 1, 32'h100 + i, 0, 0);
    chk("h_full", h_full, 1);
    chk("h_full_ready", h_ready, 0);
    for (int i = 0; i < 5; i++) hcyc(0, 0, 0, 1, 32'h100 + i);
    chk("h_fill_pass", h_pass, 4);
    chk("h_fill_underrun", h_under, 1);
    hcyc(1, 0, 0, 0, 0);
    hcyc(0, 1, 32'h200, 0, 0);
    for (int i = 1; i < 9; i++) hcyc(0, 1, 32'h200 + i, 1, 32'h200 + i - 1);
    hcyc(0, 0, 0, 1, 32'h208);
    chk("h_sat_pass", h_pass, 7);
    chk("h_sat_idx", h_idx, 7);
    chk("h_sat_fail", h_fail, 0);
    chk("h_sat_empty", h_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_scoreboard.md
Name: fpu_scoreboard

Overview:
- Synthesizable self-checking scoreboard for FPU add/mul result streams; replaces per-bench hand-aligned delay checking.
- Buffers expected results and flags in a FIFO, then compares each DUT result in order as it returns.
- Counts passes, data failures and flag failures, and captures the first failing case.
- Handles any DUT latency, including variable latency, because results are matched by order, not by cycle count.
- Sits beside the FPU in simulation and FPGA regression harnesses.

Parameters:
- WIDTH, 32: result word width; 32 = single precision, 64 = double precision.
- EXP_W, 8: exponent field width; use 11 when WIDTH = 64.
- DEPTH, 16: expected-result FIFO depth; power of two, at least 2.
- CNT_W, 16: width of the counters and the case index.
- STOP_ON_FAIL, 0: when 1, the block halts on the first data mismatch.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- clear  in  1  synchronous clear: empty FIFO, zero counters, drop capture, go to IDLE
- exp_valid  in  1  expected entry valid
- exp_ready  out  1  FIFO can accept an expected entry
- exp_data  in  WIDTH  expected {sign, exponent, mantissa}
- exp_flags  in  5  expected {invalid, overflow, underflow, inexact, zero}
- dut_valid  in  1  DUT result valid (no backpressure on the DUT)
- dut_data  in  WIDTH  DUT result
- dut_flags  in  5  DUT flags, same bit order as exp_flags
- pass_cnt  out  CNT_W  data matches
- fail_cnt  out  CNT_W  data mismatches
- flag_fail_cnt  out  CNT_W  flag mismatches
- case_idx  out  CNT_W  number of results compared so far
- underrun_err  out  1  sticky: DUT result arrived with FIFO empty
- first_fail_vld  out  1  first-failure capture is valid
- first_fail_idx  out  CNT_W  case index of the first failure
- first_fail_got  out  WIDTH  DUT data of the first failure
- first_fail_exp  out  WIDTH  expected data of the first failure
- halted  out  1  state machine is in HALT
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full

Behaviour:
- Reset values (rst low): all counters 0, case_idx 0, underrun_err 0, first_fail_* 0, halted 0, FIFO empty, state IDLE.
- FSM IDLE: exp_ready = !fifo_full. First accepted push moves to RUN.
- FSM RUN: push and pop active. A data mismatch with STOP_ON_FAIL = 1 moves to HALT.
- FSM HALT: exp_ready = 0 and dut_valid is ignored. Counters and capture are frozen. Leaves only via clear, to IDLE.
- Push: on exp_valid && exp_ready, store {exp_data, exp_flags}.
- Full FIFO: exp_ready = 0 even if a pop happens in the same cycle; no pass-through.
- Pop: on dut_valid && !fifo_empty in IDLE/RUN, pop the head and compare.
  - Data and flag results are compared independently.
  - A data match increments pass_cnt; a mismatch increments fail_cnt.
  - Any flag mismatch increments flag_fail_cnt.
  - case_idx increments on every pop.
- Pop timing: outputs update one cycle after dut_valid (registered compare).
- Push and pop in the same cycle with the FIFO neither empty nor full: both happen; occupancy is unchanged.
- Underrun: dut_valid with the FIFO empty, including an empty FIFO with a push in the same cycle, sets underrun_err. No counters change and the pushed entry is retained.
- Counters saturate at 2^CNT_W - 1; no wrap.
- First failure: the first data mismatch since reset or clear loads first_fail_* and sets first_fail_vld. Later failures do not overwrite it.
- Clear: highest-priority synchronous action; beats a push or pop in the same cycle. Clears everything that reset clears.
- Reset mid-stream: all in-flight expected entries are discarded.
- Field split is derived from WIDTH and EXP_W: sign = MSB, exponent = next EXP_W bits, mantissa = the rest.

Optional Feature:
- FPU_SB_NAN_CANON_EN defined:
  - A data compare passes when both words are NaN (exponent all ones, mantissa nonzero), regardless of sign or payload.
  - Example: 0x7FC00000 matches 0xFFFFFFFF.
- Not defined:
  - Strict bitwise compare.
  - NaN-vs-NaN payload differences count as failures.

Test Plan:
- Reset, push 0x40400000 (3.0, flags 00000); 3 cycles later dut 0x40400000 flags 00000 -> pass_cnt=1, fail_cnt=0, case_idx=1, one cycle after dut_valid.
- Push 16 entries with no DUT activity -> fifo_full=1, exp_ready=0, 17th push rejected; 16 matching results -> pass_cnt=16, fifo_empty=1.
- Push 0x3F800000 then 0x40000000; dut returns 0x3F800000 then 0x40000001 -> pass=1, fail=1, first_fail_idx=1, first_fail_got=0x40000001, first_fail_exp=0x40000000.
- STOP_ON_FAIL=1: 3 pushes, second dut result mismatches -> halted=1, third dut result ignored, exp_ready=0; pulse clear -> IDLE, all counters 0.
- dut_valid with FIFO empty -> underrun_err=1, counters unchanged; expected 0x7F800000 flags 01001 vs dut flags 01000 -> pass_cnt+1, flag_fail_cnt+1.
- Expected 0x7FC00000 vs dut 0xFFFFFFFF -> pass with FPU_SB_NAN_CANON_EN defined; fail_cnt+1 without it.
